// File: rtl/mcu_pkg.sv
// Shared definitions for the multicycle control unit: state encodings, opcodes, mux codes.
// MCU_ADDI_EN adds the ADDI opcode and its two execution states.
package mcu_pkg;

    localparam int OP_W = 6;
    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
`ifdef MCU_ADDI_EN
        , S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
`endif
    } state_t;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;
`ifdef MCU_ADDI_EN
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
`endif

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Moore control word; fetch_wr and pc_write_cond are qualified by MemReady/Zero in the top.
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       fetch_wr;
        logic       pc_write;
        logic       pc_write_cond;
    } ctrl_t;

endpackage

// File: rtl/mcu_out_decode.sv
// Purely combinational state -> Moore control word map for the multicycle control unit.
// MCU_ADDI_EN adds decoding for the ADDI execute/writeback states.
module mcu_out_decode
    import mcu_pkg::*;
(
    input  logic [ST_W-1:0] state,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.fetch_wr  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_BROFF;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
`ifdef MCU_ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            // IDLE and unlisted encodings keep every output low
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS-subset CPU: state register, next-state, Mealy gating.
// Define MCU_ADDI_EN to accept the ADDI opcode.
module multicycle_control
    import mcu_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6,
    parameter int STATE_WIDTH  = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [OPCODE_WIDTH-1:0] Op,
    input  logic                    Zero,
    input  logic                    MemReady,
    output logic                    PCEn,
    output logic                    IorD,
    output logic                    MemRead,
    output logic                    MemWrite,
    output logic                    IRWrite,
    output logic                    MemtoReg,
    output logic                    RegDst,
    output logic                    RegWrite,
    output logic                    ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [1:0]              ALUOp,
    output logic [1:0]              PCSource,
    output logic                    IllegalOp,
    output logic [STATE_WIDTH-1:0]  state_dbg
);

    state_t state_q;
    state_t state_d;
    logic   illegal;
    ctrl_t  ctrl;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        illegal = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MCU_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef MCU_ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    mcu_out_decode u_out_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // IRWrite/PCEn in FETCH and PCEn in BRANCH depend on inputs within the same cycle
    assign PCEn      = ctrl.pc_write | (ctrl.pc_write_cond & Zero) | (ctrl.fetch_wr & MemReady);
    assign IRWrite   = ctrl.fetch_wr & MemReady;
    assign IorD      = ctrl.iord;
    assign MemRead   = ctrl.mem_read;
    assign MemWrite  = ctrl.mem_write;
    assign MemtoReg  = ctrl.mem_to_reg;
    assign RegDst    = ctrl.reg_dst;
    assign RegWrite  = ctrl.reg_write;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOp     = ctrl.alu_op;
    assign PCSource  = ctrl.pc_source;
    assign IllegalOp = illegal;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control words checked through a queue.
// Honours MCU_ADDI_EN the same way the design does.
module tb_multicycle_control;
    import mcu_pkg::*;

    localparam int W = 20;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] Op = 6'b0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b1;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_dbg;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    multicycle_control dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Op        (Op),
        .Zero      (Zero),
        .MemReady  (MemReady),
        .PCEn      (PCEn),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .MemtoReg  (MemtoReg),
        .RegDst    (RegDst),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .PCSource  (PCSource),
        .IllegalOp (IllegalOp),
        .state_dbg (state_dbg)
    );

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010: return 1'b1;
`ifdef MCU_ADDI_EN
            6'b001000: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Control word the state table calls for: {state, PCEn..ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp}
    function automatic logic [W-1:0] exp_vec(input state_t st, input logic [5:0] op,
                                             input logic mr, input logic z);
        logic pcen, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
        logic [1:0] srcb, aop, pcs;
        {pcen, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill} = '0;
        {srcb, aop, pcs} = '0;
        case (st)
            S_FETCH:  begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcen = mr; end
            S_DECODE: begin srcb = 2'b11; ill = !is_legal(op); end
            S_MEMADR: begin srca = 1'b1; srcb = 2'b10; end
            S_MEMRD:  begin mrd = 1'b1; iord = 1'b1; end
            S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
            S_MEMWR:  begin mwr = 1'b1; iord = 1'b1; end
            S_EXEC:   begin srca = 1'b1; aop = 2'b10; end
            S_ALUWB:  begin rw = 1'b1; rdst = 1'b1; end
            S_BRANCH: begin srca = 1'b1; aop = 2'b01; pcs = 2'b01; pcen = z; end
            S_JUMP:   begin pcs = 2'b10; pcen = 1'b1; end
`ifdef MCU_ADDI_EN
            S_ADDIEX: begin srca = 1'b1; srcb = 2'b10; end
            S_ADDIWB: begin rw = 1'b1; end
`endif
            default: ;
        endcase
        return {st, pcen, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, ill};
    endfunction

    task automatic check_now(input string tag);
        logic [W-1:0] obs;
        logic [W-1:0] exp;
        obs = {state_dbg, PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue the expected word, compare on the falling edge.
    task automatic step(input state_t st, input logic mr, input logic z, input string tag);
        MemReady = mr;
        Zero     = z;
        exp_q.push_back(exp_vec(st, Op, mr, z));
        @(negedge Clk);
        check_now($sformatf("%s/%s", tag, st.name()));
        @(posedge Clk);
        #1;
    endtask

    task automatic run_op(input logic [5:0] op, input logic z, input int fw, input int mw,
                          input string tag);
        Op = op;
        repeat (fw) step(S_FETCH, 1'b0, rb(), tag);
        step(S_FETCH, 1'b1, rb(), tag);
        step(S_DECODE, rb(), rb(), tag);
        if (!is_legal(op)) return;
        case (op)
            6'b100011: begin
                step(S_MEMADR, rb(), rb(), tag);
                repeat (mw) step(S_MEMRD, 1'b0, rb(), tag);
                step(S_MEMRD, 1'b1, rb(), tag);
                step(S_MEMWB, rb(), rb(), tag);
            end
            6'b101011: begin
                step(S_MEMADR, rb(), rb(), tag);
                repeat (mw) step(S_MEMWR, 1'b0, rb(), tag);
                step(S_MEMWR, 1'b1, rb(), tag);
            end
            6'b000000: begin
                step(S_EXEC, rb(), rb(), tag);
                step(S_ALUWB, rb(), rb(), tag);
            end
            6'b000100: step(S_BRANCH, rb(), z, tag);
            6'b000010: step(S_JUMP, rb(), rb(), tag);
`ifdef MCU_ADDI_EN
            6'b001000: begin
                step(S_ADDIEX, rb(), rb(), tag);
                step(S_ADDIWB, rb(), rb(), tag);
            end
`endif
            default: ;
        endcase
    endtask

    logic [5:0] legal_ops [5] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};

    initial begin
        // Power-on reset: asynchronous entry to IDLE, held through two edges
        #2 Reset = 1'b0;
        #1;
        exp_q.push_back(exp_vec(S_IDLE, Op, MemReady, Zero));
        check_now("por_async");
        step(S_IDLE, 1'b1, 1'b1, "por");
        step(S_IDLE, 1'b1, 1'b1, "por");
        Reset = 1'b1;
        step(S_IDLE, 1'b1, 1'b1, "por_release");

        run_op(6'b000000, 1'b0, 0, 0, "r_type");
        run_op(6'b100011, 1'b0, 0, 2, "lw_wait2");
        run_op(6'b101011, 1'b0, 0, 1, "sw_wait1");
        run_op(6'b000100, 1'b1, 0, 0, "beq_taken");
        run_op(6'b000100, 1'b0, 0, 0, "beq_not_taken");
        run_op(6'b000010, 1'b0, 0, 0, "jump");
        run_op(6'b111111, 1'b0, 0, 0, "illegal");
        run_op(6'b001000, 1'b0, 0, 0, "addi");
        run_op(6'b100011, 1'b0, 2, 0, "lw_fetch_wait");
        run_op(6'b000000, 1'b0, 1, 0, "r_fetch_wait");

        for (int i = 0; i < 8; i++) begin
            run_op(legal_ops[$urandom_range(0, 4)], rb(), $urandom_range(0, 2),
                   $urandom_range(0, 2), $sformatf("rand%0d", i));
        end

        // Reset dropped while a store is stalled: strobes must vanish at once
        Op = 6'b101011;
        step(S_FETCH, 1'b1, 1'b0, "mid_reset");
        step(S_DECODE, 1'b1, 1'b0, "mid_reset");
        step(S_MEMADR, 1'b1, 1'b0, "mid_reset");
        step(S_MEMWR, 1'b0, 1'b0, "mid_reset");
        MemReady = 1'b1;
        Reset = 1'b0;
        #1;
        exp_q.push_back(exp_vec(S_IDLE, Op, MemReady, Zero));
        check_now("mid_reset_async");
        step(S_IDLE, 1'b1, 1'b1, "mid_reset_hold");
        step(S_IDLE, 1'b1, 1'b1, "mid_reset_hold");
        Reset = 1'b1;
        step(S_IDLE, 1'b1, 1'b1, "mid_reset_release");
        run_op(6'b000000, 1'b0, 0, 0, "r_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
